// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch stage and the
// immediate-extender op decode.
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [1:0] EOP_ZERO = 2'b00;
    localparam logic [1:0] EOP_SIGN = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_BR   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifu_fetch_eop_decode.sv
// Opcode to immediate-extender op decode; purely combinational so the
// control unit can reuse it as-is.
module eop_decode
    import ifu_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [1:0] eop_o
);

    always_comb begin
        eop_o = EOP_ZERO;
        case (opcode_i)
            OP_ORI, OP_ANDI:         eop_o = EOP_ZERO;
            OP_LW, OP_SW, OP_ADDIU:  eop_o = EOP_SIGN;
            OP_LUI:                  eop_o = EOP_LUI;
            OP_BEQ, OP_BNE:          eop_o = EOP_BR;
            default:                 eop_o = EOP_ZERO;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, one-at-a-time req/ack fetch, instruction
// register and a valid/ready output toward decode/ext, with PC redirect.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [15:0] imm,
    output logic [1:0]  EOp,
    output logic [1:0]  dbg_state
);

    // Output handshake: out_valid is high in VALID and stays high with
    // stable payload until a cycle where out_ready is also high; that
    // cycle consumes the instruction, even if a redirect arrives with it.

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [1:0]  eop_q, eop_d;
    logic [1:0]  eop_dec;

    eop_decode u_eop_decode (
        .opcode_i (imem_rdata[31:26]),
        .eop_o    (eop_dec)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        eop_d    = eop_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    eop_d    = eop_dec;
                    state_d  = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A redirect overrides the increment and throws away any word
        // returned in the same cycle.
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            eop_d    = eop_q;
            state_d  = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pc_out_q <= RESET_PC;
            eop_q    <= EOP_ZERO;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            eop_q    <= eop_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign out_valid = (state_q == ST_VALID);
    assign instr     = instr_q;
    assign pc_out    = pc_out_q;
    assign imm       = instr_q[15:0];
    assign EOp       = eop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: bench-side memory responder, PC model
// and an expected-instruction queue compared at each output handshake.
module tb_ifu_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic [1:0]  dbg_state;

    // Second instance with the PC parked at the top of the address space.
    logic        b_reset;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        b_redirect;
    logic [31:0] b_redirect_pc;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_instr;
    logic [31:0] b_pc_out;
    logic [15:0] b_imm;
    logic [1:0]  b_eop;
    logic [1:0]  b_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [65:0] exp_q[$];
    logic [31:0] pc_m;

    ifu_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .imm         (imm),
        .EOp         (eop),
        .dbg_state   (dbg_state)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .reset       (b_reset),
        .imem_req    (b_req),
        .imem_addr   (b_addr),
        .imem_ack    (b_ack),
        .imem_rdata  (b_rdata),
        .redirect    (b_redirect),
        .redirect_pc (b_redirect_pc),
        .out_valid   (b_valid),
        .out_ready   (b_ready),
        .instr       (b_instr),
        .pc_out      (b_pc_out),
        .imm         (b_imm),
        .EOp         (b_eop),
        .dbg_state   (b_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] eop_model(input logic [5:0] op);
        case (op)
            6'h0D, 6'h0C:        return 2'b00;
            6'h23, 6'h2B, 6'h09: return 2'b01;
            6'h0F:               return 2'b10;
            6'h04, 6'h05:        return 2'b11;
            default:             return 2'b00;
        endcase
    endfunction

    // Drivers
    task automatic fetch(input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("req_wait", imem_req, 1);
            chk("addr_wait", imem_addr, pc_m);
            tick();
        end
        chk("req", imem_req, 1);
        chk("addr", imem_addr, pc_m);
        chk("valid_in_fetch", out_valid, 0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        exp_q.push_back({pc_m, word, eop_model(word[31:26])});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid_rise", out_valid, 1);
        chk("req_off", imem_req, 0);
    endtask

    // Scoreboard compare against the oldest expected instruction.
    task automatic check_out(input string tag);
        logic [65:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_queue: got empty expected entry", tag);
        end else begin
            e = exp_q[0];
            chk({tag, "_pc_out"}, pc_out, e[65:34]);
            chk({tag, "_instr"}, instr, e[33:2]);
            chk({tag, "_imm"}, imm, e[17:2]);
            chk({tag, "_eop"}, eop, e[1:0]);
        end
    endtask

    task automatic accept(input int stall, input logic redir, input logic [31:0] rpc);
        for (int i = 0; i < stall; i++) begin
            check_out("stall");
            chk("stall_valid", out_valid, 1);
            chk("stall_req", imem_req, 0);
            chk("stall_addr", imem_addr, pc_m);
            tick();
        end
        check_out("accept");
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        out_ready = 1'b1;
        if (redir) begin
            redirect    = 1'b1;
            redirect_pc = rpc;
        end
        tick();
        out_ready = 1'b0;
        redirect  = 1'b0;
        pc_m = redir ? {rpc[31:2], 2'b00} : pc_m + 32'd4;
        chk("post_valid", out_valid, 0);
        chk("post_req", imem_req, 1);
        chk("post_addr", imem_addr, pc_m);
    endtask

    logic [5:0] op_tab [10] = '{6'h0D, 6'h0C, 6'h23, 6'h2B, 6'h09,
                                6'h0F, 6'h04, 6'h05, 6'h00, 6'h3F};

    initial begin
        logic [31:0] w;
        logic [31:0] r;
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        b_reset = 1'b1; b_ack = 1'b0; b_rdata = 32'd0;
        b_redirect = 1'b0; b_redirect_pc = 32'd0; b_ready = 1'b0;
        pc_m = 32'h0000_3000;

        // Reset with ack held high
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", imem_addr, 32'h3000);
        chk("rst_instr", instr, 0);
        chk("rst_imm", imm, 0);
        chk("rst_eop", eop, 0);
        chk("rst_pc_out", pc_out, 32'h3000);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h3000);

        // ori in first fetch cycle, then 5-cycle stall
        fetch(32'h3421_00FF, 0);
        chk("ori_imm", imm, 16'h00FF);
        chk("ori_eop", eop, 2'b00);
        chk("ori_pc_out", pc_out, 32'h3000);
        accept(5, 1'b0, 32'd0);
        chk("next_addr", imem_addr, 32'h3004);

        // Delayed ack coinciding with a redirect: word discarded
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_req", imem_req, 1);
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h3C01_AAAA;
        redirect = 1'b1; redirect_pc = 32'h0000_4003;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        pc_m = 32'h0000_4000;
        chk("rd_valid", out_valid, 0);
        chk("rd_req", imem_req, 1);
        chk("rd_addr", imem_addr, 32'h4000);
        chk("rd_instr_kept", instr, 32'h3421_00FF);
        tick();
        chk("rd_valid2", out_valid, 0);
        chk("rd_addr2", imem_addr, 32'h4000);

        // lui and beq
        fetch(32'h3C01_1234, 0);
        chk("lui_eop", eop, 2'b10);
        accept(0, 1'b0, 32'd0);
        fetch(32'h1022_FFFE, 1);
        chk("beq_eop", eop, 2'b11);
        chk("beq_imm", imm, 16'hFFFE);
        accept(1, 1'b0, 32'd0);

        // Redirect together with ready in VALID: consumed, PC replaced
        fetch(32'h3021_0001, 2);
        accept(0, 1'b1, 32'h0000_8001);

        // Randomised opcodes, ack delays and ready stalls
        for (int n = 0; n < 12; n++) begin
            r = $urandom;
            w = {op_tab[$urandom_range(0, 9)], r[25:0]};
            fetch(w, $urandom_range(0, 3));
            accept($urandom_range(0, 3), 1'b0, 32'd0);
        end

        // Reset mid-VALID with an ack pending
        fetch(32'h8C22_0010, 0);
        reset = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_req", imem_req, 0);
        chk("mrst_instr", instr, 0);
        chk("mrst_eop", eop, 0);
        chk("mrst_pc_out", pc_out, 32'h3000);
        chk("mrst_addr", imem_addr, 32'h3000);
        exp_q.delete();
        reset = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
        pc_m = 32'h0000_3000;
        tick();
        fetch(32'hAC22_0004, 1);
        accept(0, 1'b0, 32'd0);

        // PC wrap on the second instance
        chk("wrap_rst_req", b_req, 0);
        chk("wrap_rst_addr", b_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_pc_out", b_pc_out, 32'hFFFF_FFFC);
        b_reset = 1'b0;
        tick();
        chk("wrap_req", b_req, 1);
        chk("wrap_addr", b_addr, 32'hFFFF_FFFC);
        b_ack = 1'b1; b_rdata = 32'h2401_0005;
        tick();
        b_ack = 1'b0;
        chk("wrap_valid", b_valid, 1);
        chk("wrap_eop", b_eop, 2'b01);
        chk("wrap_instr", b_instr, 32'h2401_0005);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("wrap_next_req", b_req, 1);
        chk("wrap_next_addr", b_addr, 32'h0000_0000);

        // Report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage feeding the immediate extender. It holds the PC, fetches one instruction at a time over a req/ack memory port, and latches the word into an instruction register. It presents the instruction, its `imm` field and the decoded `EOp` selector to downstream decode/ext through a valid/ready handshake. It also accepts PC redirects from branch/jump resolution.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  32  word address; equals `pc` while `imem_req` is high.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; ignored unless `imem_req` is high.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack` is high.
- `redirect`  in  1  replace the PC this cycle.
- `redirect_pc`  in  32  new PC; bits [1:0] forced to 00.
- `out_valid`  out  1  `instr`/`pc_out`/`imm`/`EOp` are valid.
- `out_ready`  in  1  downstream accepts the current instruction.
- `instr`  out  32  latched instruction register.
- `pc_out`  out  32  PC of `instr`.
- `imm`  out  16  `instr[15:0]`.
- `EOp`  out  2  extender op, registered together with `instr`.

## Operation
- States: IDLE, FETCH, VALID.
- IDLE: entered on reset; goes to FETCH on the next cycle unconditionally.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. When `imem_ack` is high:
  - `instr` <= `imem_rdata`.
  - `pc_out` <= `pc`.
  - `EOp` <= decode(`imem_rdata[31:26]`).
  - Next state is VALID.
- VALID: `out_valid`=1. When `out_ready` is high, `pc` <= `pc`+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and next state is FETCH.
- VALID contents are stable: `instr`, `imm`, `EOp` and `pc_out` hold while `out_valid` is high and `out_ready` is low.
- EOp decode, by opcode:
  - 6'h0D ori, 6'h0C andi: 00, zero-extend.
  - 6'h23 lw, 6'h2B sw, 6'h09 addiu: 01, sign-extend.
  - 6'h0F lui: 10, imm<<16.
  - 6'h04 beq, 6'h05 bne: 11, sign-extend then <<2.
  - Any other opcode: 00.
- Redirect has priority over everything except reset. In any state:
  - `pc` <= {`redirect_pc[31:2]`,2'b00}.
  - `out_valid` drops next cycle.
  - Next state is FETCH.
  - If `imem_ack` arrives in the same cycle, the returned word is discarded.
  - If `out_ready` is high in VALID in the same cycle, the handshake completes (the instruction is consumed) but the +4 increment is overridden by the redirect.
- Reset, including mid-fetch or mid-VALID: state <= IDLE, `pc` <= `RESET_PC`, `instr` <= 0, `pc_out` <= `RESET_PC`, `EOp` <= 00. Any pending ack is dropped.

## Timing
- Reset values: `imem_req`=0, `out_valid`=0, `imem_addr`=`RESET_PC`, `instr`=0, `imm`=0, `EOp`=00, `pc_out`=`RESET_PC`.
- First `imem_req` occurs 1 cycle after `reset` deasserts (the IDLE cycle).
- With `imem_ack` in the first FETCH cycle, `out_valid` rises on the next cycle. Fetch-to-valid latency is 1 cycle after ack.
- Peak throughput is one instruction per 2 cycles (FETCH, VALID) with ack and ready always high.
- `imem_req`, `imem_addr` and `out_valid` are decoded from registered state only. No combinational path runs from `imem_ack`, `out_ready` or `redirect` to any output.

## Structure
- Package `ifu_pkg`:
  - State enum (IDLE/FETCH/VALID).
  - Opcode constants (ORI, ANDI, LW, SW, ADDIU, LUI, BEQ, BNE).
  - EOp codes: EOP_ZERO=00, EOP_SIGN=01, EOP_LUI=10, EOP_BR=11.
  - Default `RESET_PC`.
- Sub-module `eop_decode`: combinational, opcode[5:0] -> EOp[1:0]. It is shared with the later control unit.

## Test plan
- Reset with `imem_ack` held high: `imem_req`=0 and `out_valid`=0 during reset. One cycle after release, `imem_req`=1 with `imem_addr`=32'h3000.
- Ack 32'h3421_00FF (ori) in the first FETCH cycle -> next cycle `out_valid`=1, `imm`=16'h00FF, `EOp`=00, `pc_out`=32'h3000. Next fetch address after `out_ready` is 32'h3004.
- Hold `out_ready`=0 for 5 cycles -> outputs stable, no `imem_req`. On ready, exactly one increment.
- Delay ack 3 cycles, assert `redirect`=1 with `redirect_pc`=32'h0000_4003 in the same cycle as the ack -> word discarded, next `imem_addr`=32'h4000, `out_valid` stays 0.
- Fetch 32'h3C01_1234 (lui) -> `EOp`=10. Fetch 32'h1022_FFFE (beq) -> `EOp`=11, `imm`=16'hFFFE.
- Set `RESET_PC`=32'hFFFF_FFFC, complete one handshake -> next `imem_addr`=32'h0000_0000.
